switch: RTL and testbench

- Inter-core data switch for the vector multicore.
- Each of CORE_SIZE vector cores can send one WIDTH-lane vector of single-precision floats to any core, including itself, and can receive one vector from a named source core.
- Transfers go through one-entry mailboxes, one per (source, destination) pair.
- The switch sits beside the VecCore array; each core's switch_* signals connect to its index in the port arrays.

---
 rtl/switch.sv | 124 ++++++++++++
 tb/tb_switch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch.sv
// Inter-core vector switch: one single-entry mailbox per (source, destination) core pair.
// Lanes are carried as raw 32-bit IEEE-754 words, so transfers are bit-exact.
module switch #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned CORE_SIZE      = 2,
  parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      send_ready    [CORE_SIZE],
  input  logic [CORE_ADDR_SIZE-1:0] send_core_idx [CORE_SIZE],
  input  logic [31:0]               send_data     [CORE_SIZE][WIDTH],
  output logic                      send_ok       [CORE_SIZE],

  input  logic                      recv_request  [CORE_SIZE],
  input  logic [CORE_ADDR_SIZE-1:0] recv_core_idx [CORE_SIZE],
  output logic                      recv_ready    [CORE_SIZE],
  output logic [31:0]               recv_data     [CORE_SIZE][WIDTH]
);

  localparam int unsigned IdxSpan = 2 ** CORE_ADDR_SIZE;

  logic        full_q [CORE_SIZE][CORE_SIZE];
  logic        full_d [CORE_SIZE][CORE_SIZE];
  logic [31:0] mbox_q [CORE_SIZE][CORE_SIZE][WIDTH];

  // drain[s][d]: mailbox (s,d) is consumed this cycle; wr[s][d]: it is written this cycle
  logic        drain  [CORE_SIZE][CORE_SIZE];
  logic        wr     [CORE_SIZE][CORE_SIZE];

  // Index fields can encode values past CORE_SIZE when it is not a power of two.
  logic [IdxSpan-1:0] idx_valid;

  always_comb begin
    idx_valid = '0;
    for (int i = 0; i < int'(IdxSpan); i++) begin
      idx_valid[i] = (i < int'(CORE_SIZE));
    end
  end

  // Receive side: a destination sees the mailbox from its chosen source only if it is full.
  always_comb begin
    for (int d = 0; d < int'(CORE_SIZE); d++) begin
      recv_ready[d] = 1'b0;
      for (int l = 0; l < int'(WIDTH); l++) begin
        recv_data[d][l] = '0;
      end
      if (!reset && recv_request[d] && idx_valid[recv_core_idx[d]]) begin
        if (full_q[recv_core_idx[d]][d]) begin
          recv_ready[d] = 1'b1;
          recv_data[d]  = mbox_q[recv_core_idx[d]][d];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < int'(CORE_SIZE); s++) begin
      for (int d = 0; d < int'(CORE_SIZE); d++) begin
        drain[s][d] = 1'b0;
      end
    end
    for (int d = 0; d < int'(CORE_SIZE); d++) begin
      if (recv_ready[d]) begin
        drain[recv_core_idx[d]][d] = 1'b1;
      end
    end
  end

  // Send side: a full mailbox still accepts if it is being drained in the same cycle.
  always_comb begin
    for (int s = 0; s < int'(CORE_SIZE); s++) begin
      send_ok[s] = 1'b0;
      for (int d = 0; d < int'(CORE_SIZE); d++) begin
        wr[s][d] = 1'b0;
      end
      if (!reset && send_ready[s] && idx_valid[send_core_idx[s]]) begin
        if (!full_q[s][send_core_idx[s]] || drain[s][send_core_idx[s]]) begin
          send_ok[s]               = 1'b1;
          wr[s][send_core_idx[s]]  = 1'b1;
        end
      end
    end
  end

  // A write in the same cycle as a drain wins: the new vector stays resident.
  always_comb begin
    for (int s = 0; s < int'(CORE_SIZE); s++) begin
      for (int d = 0; d < int'(CORE_SIZE); d++) begin
        if (wr[s][d]) begin
          full_d[s][d] = 1'b1;
        end else if (drain[s][d]) begin
          full_d[s][d] = 1'b0;
        end else begin
          full_d[s][d] = full_q[s][d];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < int'(CORE_SIZE); s++) begin
        for (int d = 0; d < int'(CORE_SIZE); d++) begin
          full_q[s][d] <= 1'b0;
          for (int l = 0; l < int'(WIDTH); l++) begin
            mbox_q[s][d][l] <= '0;
          end
        end
      end
    end else begin
      for (int s = 0; s < int'(CORE_SIZE); s++) begin
        for (int d = 0; d < int'(CORE_SIZE); d++) begin
          full_q[s][d] <= full_d[s][d];
          if (wr[s][d]) begin
            mbox_q[s][d] <= send_data[s];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch.sv
// Self-checking bench for switch: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a mailbox-level reference model.
module tb_switch;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int AW = $clog2(N);

  localparam logic [31:0] F1 = 32'h3F80_0000;  // 1.0
  localparam logic [31:0] F2 = 32'h4000_0000;  // 2.0
  localparam logic [31:0] F3 = 32'h4040_0000;  // 3.0
  localparam logic [31:0] F4 = 32'h4080_0000;  // 4.0
  localparam logic [31:0] F9 = 32'h4110_0000;  // 9.0

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          send_ready    [N];
  logic [AW-1:0] send_core_idx [N];
  logic [31:0]   send_data     [N][W];
  logic          send_ok       [N];
  logic          recv_request  [N];
  logic [AW-1:0] recv_core_idx [N];
  logic          recv_ready    [N];
  logic [31:0]   recv_data     [N][W];

  switch #(
    .WIDTH     (W),
    .CORE_SIZE (N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .recv_request  (recv_request),
    .recv_core_idx (recv_core_idx),
    .recv_ready    (recv_ready),
    .recv_data     (recv_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: mailbox contents and the handshakes expected this cycle.
  bit          m_full [N][N];
  logic [31:0] m_mem  [N][N][W];
  bit          e_so   [N];
  bit          e_rr   [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // IEEE-754 single encoding of k/2 for small positive k.
  function automatic logic [31:0] halves(input int k);
    int e = 0;
    if (k == 0) return 32'h0;
    while ((k >> (e + 1)) != 0) e++;
    return 32'((e + 126) << 23) | (32'(k << (23 - e)) & 32'h007F_FFFF);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < N; s++)
      for (int d = 0; d < N; d++) begin
        m_full[s][d] = 1'b0;
        for (int l = 0; l < W; l++) m_mem[s][d][l] = 32'h0;
      end
  endtask

  task automatic idle();
    for (int c = 0; c < N; c++) begin
      send_ready[c]    = 1'b0;
      send_core_idx[c] = '0;
      recv_request[c]  = 1'b0;
      recv_core_idx[c] = '0;
      for (int l = 0; l < W; l++) send_data[c][l] = 32'h0;
    end
  endtask

  task automatic snd(input int c, input int dst, input logic [31:0] val);
    send_ready[c]    = 1'b1;
    send_core_idx[c] = AW'(dst);
    for (int l = 0; l < W; l++) send_data[c][l] = val;
  endtask

  task automatic rcv(input int c, input int src);
    recv_request[c]  = 1'b1;
    recv_core_idx[c] = AW'(src);
  endtask

  // Let inputs settle, derive expectations from the model, compare every output.
  task automatic settle();
    int src, dst;
    logic [31:0] exp;
    #1;
    if (reset) model_clear();
    for (int d = 0; d < N; d++) begin
      src     = int'(recv_core_idx[d]);
      e_rr[d] = !reset && recv_request[d] && src < N && m_full[src][d];
    end
    for (int s = 0; s < N; s++) begin
      dst     = int'(send_core_idx[s]);
      e_so[s] = !reset && send_ready[s] && dst < N &&
                (!m_full[s][dst] || (e_rr[dst] && int'(recv_core_idx[dst]) == s));
    end
    for (int c = 0; c < N; c++) begin
      check($sformatf("send_ok[%0d]", c), 32'(send_ok[c]), 32'(e_so[c]));
      check($sformatf("recv_ready[%0d]", c), 32'(recv_ready[c]), 32'(e_rr[c]));
      for (int l = 0; l < W; l++) begin
        exp = e_rr[c] ? m_mem[int'(recv_core_idx[c])][c][l] : 32'h0;
        check($sformatf("recv_data[%0d][%0d]", c, l), recv_data[c][l], exp);
      end
    end
  endtask

  // Clock edge: consume accepted receives, then store accepted sends.
  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      for (int d = 0; d < N; d++)
        if (e_rr[d]) m_full[int'(recv_core_idx[d])][d] = 1'b0;
      for (int s = 0; s < N; s++)
        if (e_so[s]) begin
          m_full[s][int'(send_core_idx[s])] = 1'b1;
          m_mem[s][int'(send_core_idx[s])]  = send_data[s];
        end
    end
    @(negedge clock);
  endtask

  initial begin
    idle();
    model_clear();
    reset = 1'b1;
    settle();
    @(negedge clock);
    reset = 1'b0;

    // Fill two mailboxes, then assert reset with requests pending.
    snd(0, 1, F1); snd(1, 0, F2);
    settle(); tick();
    idle();
    reset = 1'b1;
    snd(0, 0, F3); rcv(1, 0); rcv(0, 1);
    settle();
    check("rst_send_ok0", 32'(send_ok[0]), 32'd0);
    check("rst_recv_ready1", 32'(recv_ready[1]), 32'd0);
    check("rst_recv_data1", recv_data[1][0], 32'h0);
    reset = 1'b0;
    idle(); rcv(1, 0);
    settle();
    check("post_rst_recv_ready1", 32'(recv_ready[1]), 32'd0);
    tick();

    // Basic transfer of lanes i*1.5.
    idle();
    send_ready[0] = 1'b1; send_core_idx[0] = AW'(1);
    for (int l = 0; l < W; l++) send_data[0][l] = halves(3 * l);
    settle();
    check("basic_send_ok0", 32'(send_ok[0]), 32'd1);
    tick();
    idle(); rcv(1, 0);
    settle();
    check("basic_recv_ready1", 32'(recv_ready[1]), 32'd1);
    check("basic_lane5", recv_data[1][5], 32'h40F0_0000);
    tick();
    settle();
    check("basic_again_ready1", 32'(recv_ready[1]), 32'd0);
    tick();

    // Back-pressure on a single pair.
    idle(); snd(0, 1, F1);
    settle(); check("bp_a_ok", 32'(send_ok[0]), 32'd1); tick();
    snd(0, 1, F2);
    settle(); check("bp_b_stall", 32'(send_ok[0]), 32'd0); tick();
    rcv(1, 0);
    settle();
    check("bp_recv_a", recv_data[1][3], F1);
    check("bp_b_ok_on_drain", 32'(send_ok[0]), 32'd1);
    tick();
    idle(); rcv(1, 0);
    settle(); check("bp_recv_b", recv_data[1][15], F2); tick();

    // Simultaneous cross traffic.
    idle(); snd(0, 1, F3); snd(1, 0, F4);
    settle();
    check("cross_ok0", 32'(send_ok[0]), 32'd1);
    check("cross_ok1", 32'(send_ok[1]), 32'd1);
    tick();
    idle(); rcv(1, 0); rcv(0, 1);
    settle();
    check("cross_recv1", recv_data[1][0], F3);
    check("cross_recv0", recv_data[0][0], F4);
    tick();

    // Self-send with an early receive: no bypass.
    idle(); rcv(1, 1); snd(1, 1, F9);
    settle(); check("self_early_ready", 32'(recv_ready[1]), 32'd0); tick();
    send_ready[1] = 1'b0;
    settle();
    check("self_ready", 32'(recv_ready[1]), 32'd1);
    check("self_data", recv_data[1][7], F9);
    tick();

    // Asynchronous reset pulse between edges with (0,1) full.
    idle(); snd(0, 1, F2);
    settle(); tick();
    idle(); rcv(1, 0);
    #2 reset = 1'b1;
    #1;
    check("pulse_recv_ready", 32'(recv_ready[1]), 32'd0);
    check("pulse_recv_data", recv_data[1][0], 32'h0);
    reset = 1'b0;
    model_clear();
    settle(); check("pulse_after_stall", 32'(recv_ready[1]), 32'd0); tick();

    // Randomized traffic with occasional resets.
    idle();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < N; c++) begin
        send_ready[c]    = $urandom_range(0, 1) == 1;
        send_core_idx[c] = AW'($urandom_range(0, (1 << AW) - 1));
        for (int l = 0; l < W; l++) send_data[c][l] = $urandom;
        recv_request[c]  = $urandom_range(0, 1) == 1;
        recv_core_idx[c] = AW'($urandom_range(0, (1 << AW) - 1));
      end
      settle();
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
